// File: rtl/cmos_stream_pkg.sv
// Shared types and helpers for the CMOS-style stream transmitter.
// Imported by the timing counter and the transmitter top.
package cmos_stream_pkg;

  localparam int CNT_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    ACTIVE,
    HBLANK
  } state_t;

  function automatic int h_total(
    input int h_act,
    input int h_blk
  );
    return h_act + h_blk;
  endfunction

endpackage

// File: rtl/cmos_timing_cnt.sv
// Pixel/line counter pair for the stream transmitter.
// Counts the displayed frame position and raises position strobes.
module cmos_timing_cnt
  import cmos_stream_pkg::*;
#(
  parameter int H_TOT    = 1440,
  parameter int H_ACTIVE = 1280,
  parameter int V_GAP    = 4,
  parameter int V_TOT    = 964
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_act_end,
  output logic o_line_end,
  output logic o_gap_end,
  output logic o_frame_end
);

  localparam logic [CNT_W-1:0] X_LAST =
    CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] X_ACT =
    CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_GAP =
    CNT_W'((V_GAP > 0) ? V_GAP - 1 : 0);
  localparam logic [CNT_W-1:0] Y_LAST =
    CNT_W'(V_TOT - 1);

  logic [CNT_W-1:0] r_xcnt;
  logic [CNT_W-1:0] r_ycnt;
  logic             w_gap_on;

  // ycnt spans gap and active lines so one compare ends the frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xcnt <= '0;
      r_ycnt <= '0;
    end else if (i_clr) begin
      r_xcnt <= '0;
      r_ycnt <= '0;
    end else if (i_en) begin
      if (o_line_end) begin
        r_xcnt <= '0;
        if (r_ycnt == Y_LAST) begin
          r_ycnt <= '0;
        end else begin
          r_ycnt <= r_ycnt + 1'b1;
        end
      end else begin
        r_xcnt <= r_xcnt + 1'b1;
      end
    end
  end

  assign w_gap_on    = (V_GAP > 0);
  assign o_line_end  = (r_xcnt == X_LAST);
  assign o_act_end   = (r_xcnt == X_ACT);
  assign o_gap_end   = w_gap_on & o_line_end &
                       (r_ycnt == Y_GAP);
  assign o_frame_end = o_line_end &
                       (r_ycnt == Y_LAST);

endmodule

// File: rtl/cmos_stream_tx.sv
// Regenerates vsync/href/data sensor timing from a valid/ready source.
// Timing never stalls; a starved source yields zero pixels and a flag.
module cmos_stream_tx
  import cmos_stream_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_BLANK  = 160,
  parameter int V_ACTIVE = 960,
  parameter int V_GAP    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       src_valid,
  input  logic [7:0] src_data,
  output logic       src_ready,
  output logic       image_out_vsync,
  output logic       image_out_href,
  output logic [7:0] image_out_data,
  output logic       frame_done,
  output logic       frame_underrun
);

  localparam int H_TOT = h_total(H_ACTIVE, H_BLANK);
  localparam int V_TOT = V_GAP + V_ACTIVE;
  localparam state_t ST_START =
    (V_GAP == 0) ? ACTIVE : GAP;

  if (H_BLANK <= 0) begin : g_bad_hblank
    $error("cmos_stream_tx: H_BLANK must be > 0");
  end
  if (H_TOT > 4095 || V_TOT > 4095) begin : g_bad_size
    $error("cmos_stream_tx: frame exceeds counters");
  end

  state_t     r_state;
  state_t     w_next;
  logic       w_clr;
  logic       w_cnt_en;
  logic       w_done;
  logic       w_start;
  logic       w_take;
  logic       w_act_end;
  logic       w_line_end;
  logic       w_gap_end;
  logic       w_frame_end;
  logic       r_vsync;
  logic       r_href;
  logic [7:0] r_data;
  logic       r_ur;
  logic       r_done;
  logic       r_fur;

  cmos_timing_cnt #(
    .H_TOT    (H_TOT),
    .H_ACTIVE (H_ACTIVE),
    .V_GAP    (V_GAP),
    .V_TOT    (V_TOT)
  ) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_clr),
    .i_en        (w_cnt_en),
    .o_act_end   (w_act_end),
    .o_line_end  (w_line_end),
    .o_gap_end   (w_gap_end),
    .o_frame_end (w_frame_end)
  );

  // r_state is the phase whose outputs are on the pins this cycle
  always_comb begin
    w_next   = r_state;
    w_clr    = 1'b0;
    w_cnt_en = 1'b0;
    w_done   = 1'b0;
    w_start  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (enable) begin
          w_next  = ST_START;
          w_clr   = 1'b1;
          w_start = 1'b1;
        end
      end
      GAP: begin
        w_cnt_en = 1'b1;
        if (w_gap_end) begin
          w_next = ACTIVE;
        end
      end
      ACTIVE: begin
        w_cnt_en = 1'b1;
        if (w_act_end) begin
          w_next = HBLANK;
        end
      end
      HBLANK: begin
        w_cnt_en = 1'b1;
        if (w_frame_end) begin
          w_done = 1'b1;
          if (enable) begin
            w_next  = ST_START;
            w_start = 1'b1;
          end else begin
            w_next = IDLE;
            w_clr  = 1'b1;
          end
        end else if (w_line_end) begin
          w_next = ACTIVE;
        end
      end
      default: begin
        w_next = IDLE;
        w_clr  = 1'b1;
      end
    endcase
  end

  assign w_take    = (w_next == ACTIVE);
  assign src_ready = ~rst & w_take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_vsync <= 1'b0;
      r_href  <= 1'b0;
      r_data  <= 8'd0;
      r_ur    <= 1'b0;
      r_done  <= 1'b0;
      r_fur   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_vsync <= (w_next == ACTIVE) |
                 (w_next == HBLANK);
      r_href  <= w_take;
      r_data  <= (w_take & src_valid) ?
                 src_data : 8'd0;
      // old bit is reported before a restart clears it
      r_ur    <= (r_ur & ~w_start) |
                 (w_take & ~src_valid);
      r_done  <= w_done;
      r_fur   <= w_done & r_ur;
    end
  end

  assign image_out_vsync = r_vsync;
  assign image_out_href  = r_href;
  assign image_out_data  = r_data;
  assign frame_done      = r_done;
  assign frame_underrun  = r_fur;

endmodule

// File: tb/tb_cmos_stream_tx.sv
// Randomised bench for cmos_stream_tx against a frame-position model.
// Small geometry: 4 px, 2 blank, 3 lines, 2 gap lines.
module tb_cmos_stream_tx;

  localparam int HA = 4;
  localparam int HB = 2;
  localparam int VA = 3;
  localparam int VG = 2;
  localparam int HT = HA + HB;
  localparam int FR = (VG + VA) * HT;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       src_valid;
  logic [7:0] src_data;
  logic       src_ready;
  logic       image_out_vsync;
  logic       image_out_href;
  logic [7:0] image_out_data;
  logic       frame_done;
  logic       frame_underrun;

  cmos_stream_tx #(
    .H_ACTIVE (HA),
    .H_BLANK  (HB),
    .V_ACTIVE (VA),
    .V_GAP    (VG)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .src_valid       (src_valid),
    .src_data        (src_data),
    .src_ready       (src_ready),
    .image_out_vsync (image_out_vsync),
    .image_out_href  (image_out_href),
    .image_out_data  (image_out_data),
    .frame_done      (frame_done),
    .frame_underrun  (frame_underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int seq = 1;
  int mode = 0;
  bit en_req = 1'b0;
  bit rst_req = 1'b1;
  bit drop_done = 1'b0;

  bit       m_run;
  int       m_p;
  bit       m_ur;
  bit       m_done;
  bit       m_fur;
  int       m_frames = 0;
  logic [7:0] m_data;

  int done_q[$];
  int fur_q[$];
  int pix_q[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %0h want %0h",
               tag, cyc, got, exp);
    end
  endtask

  function automatic bit act_pos(input int p);
    return (p / HT >= VG) && (p % HT < HA);
  endfunction

  function automatic bit vs_pos(input int p);
    return p / HT >= VG;
  endfunction

  task automatic model_reset();
    m_run  = 1'b0;
    m_p    = 0;
    m_ur   = 1'b0;
    m_done = 1'b0;
    m_fur  = 1'b0;
    m_data = 8'd0;
  endtask

  // frame position advances one per cycle; enable matters only at ends
  task automatic model_next(output bit nrun,
                            output int np,
                            output bit nd);
    nd = 1'b0;
    np = 0;
    if (!m_run) begin
      nrun = enable;
    end else if (m_p == FR - 1) begin
      nd   = 1'b1;
      nrun = enable;
    end else begin
      nrun = 1'b1;
      np   = m_p + 1;
    end
  endtask

  task automatic drive();
    bit nrun;
    bit nd;
    int np;
    int slot;
    rst    = rst_req;
    enable = en_req;
    if (rst_req) model_reset();
    model_next(nrun, np, nd);
    slot = -1;
    if (nrun && act_pos(np))
      slot = (np / HT - VG) * HA + np % HT;
    if (mode == 2) begin
      src_valid = ($urandom_range(0, 3) != 0);
      src_data  = 8'($urandom_range(0, 255));
    end else begin
      src_valid = 1'b1;
      src_data  = 8'(seq);
      if (mode == 1 && slot == 5 && !drop_done) begin
        src_valid = 1'b0;
        drop_done = 1'b1;
      end
    end
  endtask

  task automatic compare();
    bit nrun;
    bit nd;
    int np;
    model_next(nrun, np, nd);
    chk("src_ready", src_ready,
        !rst && nrun && act_pos(np));
    chk("vsync", image_out_vsync,
        m_run && vs_pos(m_p));
    chk("href", image_out_href,
        m_run && act_pos(m_p));
    chk("data", image_out_data, m_data);
    chk("frame_done", frame_done, m_done);
    if (m_done) chk("underrun", frame_underrun, m_fur);
    if (frame_done) begin
      done_q.push_back(cyc);
      fur_q.push_back(int'(frame_underrun));
    end
    if (image_out_href)
      pix_q.push_back(int'(image_out_data));
  endtask

  task automatic step();
    bit nrun;
    bit nd;
    int np;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      model_next(nrun, np, nd);
      if (src_valid && nrun && act_pos(np)) seq++;
      if (nd) begin
        m_fur = m_ur;
        m_frames++;
      end
      if (nrun && (nd || !m_run)) m_ur = 1'b0;
      m_run  = nrun;
      m_p    = np;
      m_done = nd;
      m_data = 8'd0;
      if (nrun && act_pos(np)) begin
        if (src_valid) m_data = src_data;
        else m_ur = 1'b1;
      end
    end
    #1;
    drive();
    @(negedge clk);
    compare();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_q();
    done_q.delete();
    fur_q.delete();
    pix_q.delete();
  endtask

  task automatic one_frame();
    en_req = 1'b1;
    step();
    en_req = 1'b0;
    run(40);
  endtask

  initial begin
    int d0;
    int exp_px;
    bit hit;
    rst       = 1'b1;
    enable    = 1'b0;
    src_valid = 1'b0;
    src_data  = 8'd0;
    model_reset();

    run(3);
    rst_req = 1'b0;
    run(20);
    chk("idle_done_n", done_q.size(), 0);

    clear_q();
    seq  = 1;
    mode = 0;
    one_frame();
    chk("f1_done_n", done_q.size(), 1);
    chk("f1_pix_n", pix_q.size(), 12);
    for (int i = 0; i < 12 && i < pix_q.size(); i++)
      chk("f1_pix", pix_q[i], i + 1);
    if (fur_q.size() > 0) chk("f1_ur", fur_q[0], 0);

    clear_q();
    seq       = 1;
    mode      = 1;
    drop_done = 1'b0;
    en_req    = 1'b1;
    d0        = m_frames;
    hit       = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      step();
      hit = (m_frames >= d0 + 2) &&
            (m_p / HT == VG + 1) && (m_p % HT == 1);
    end
    chk("s3_reach", hit, 1);
    en_req = 1'b0;
    run(40);
    chk("s3_done_n", done_q.size(), 3);
    if (done_q.size() == 3) begin
      chk("period_a", done_q[1] - done_q[0], FR);
      chk("period_b", done_q[2] - done_q[1], FR);
      chk("s3_ur0", fur_q[0], 1);
      chk("s3_ur1", fur_q[1], 0);
      chk("s3_ur2", fur_q[2], 0);
    end
    chk("s3_pix_n", pix_q.size(), 36);
    for (int i = 0; i < 12 && i < pix_q.size(); i++) begin
      exp_px = (i < 5) ? i + 1 : (i == 5) ? 0 : i;
      chk("s3_pix", pix_q[i], exp_px);
    end

    mode = 2;
    for (int i = 0; i < 400; i++) begin
      en_req = ($urandom_range(0, 7) != 0);
      step();
    end
    en_req = 1'b0;
    run(40);

    clear_q();
    mode   = 0;
    seq    = 1;
    en_req = 1'b1;
    hit    = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      step();
      hit = m_run && act_pos(m_p) &&
            (m_p / HT == VG + 1);
    end
    chk("s5_reach", hit, 1);
    d0      = done_q.size();
    rst_req = 1'b1;
    run(3);
    rst_req = 1'b0;
    en_req  = 1'b0;
    step();
    chk("rst_no_done", done_q.size(), d0);
    clear_q();
    seq = 1;
    one_frame();
    chk("s5_done_n", done_q.size(), 1);
    chk("s5_pix_n", pix_q.size(), 12);
    for (int i = 0; i < 12 && i < pix_q.size(); i++)
      chk("s5_pix", pix_q[i], i + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
